// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper - drives all 8 vectors into a 3-input logic cell and checks the sampled outputs.
// Each vector is held for a settle interval, then sampled over a stability window.
module truth_table_sweeper #(
  parameter logic [7:0] TRUTH         = 8'h76,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       drv_in1,
  output logic       drv_in2,
  output logic       drv_in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] captured,
  output logic [7:0] unstable,
  output logic       pass
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] STABLE_LOAD = 8'(STABLE_CYCLES - 1);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [2:0] k, k_next;
  logic [2:0] drv, drv_next;
  logic       ref_val, ref_next;
  logic       busy_next, done_next, pass_next;
  logic [7:0] captured_next, unstable_next;
  logic       sample_ref;

  assign drv_in1 = drv[2];
  assign drv_in2 = drv[1];
  assign drv_in3 = drv[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      k        <= '0;
      drv      <= '0;
      ref_val  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      captured <= '0;
      unstable <= '0;
      pass     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      k        <= k_next;
      drv      <= drv_next;
      ref_val  <= ref_next;
      busy     <= busy_next;
      done     <= done_next;
      captured <= captured_next;
      unstable <= unstable_next;
      pass     <= pass_next;
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    k_next        = k;
    drv_next      = drv;
    ref_next      = ref_val;
    busy_next     = busy;
    done_next     = 1'b0;
    captured_next = captured;
    unstable_next = unstable;
    pass_next     = pass;
    sample_ref    = ref_val;
    case (state)
      IDLE: begin
        if (start) begin
          state_next    = SETTLE;
          cnt_next      = SETTLE_LOAD;
          k_next        = '0;
          drv_next      = '0;
          busy_next     = 1'b1;
          captured_next = '0;
          unstable_next = '0;
          pass_next     = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt == 8'd0) begin
          state_next = SAMPLE;
          cnt_next   = STABLE_LOAD;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      SAMPLE: begin
        // The first window cycle establishes the reference; later cycles only compare against it.
        if (cnt == STABLE_LOAD) begin
          sample_ref = dut_out;
          ref_next   = dut_out;
        end else if (dut_out != ref_val) begin
          unstable_next[~k] = 1'b1;
        end
        if (cnt == 8'd0) begin
          captured_next[~k] = sample_ref;
          if (k == 3'd7) begin
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            drv_next   = '0;
            pass_next  = (captured_next == TRUTH) && (unstable_next == 8'd0);
          end else begin
            state_next = SETTLE;
            cnt_next   = SETTLE_LOAD;
            k_next     = k + 3'd1;
            drv_next   = k + 3'd1;
          end
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper - directed checks of the truth table sweeper with simple cell models.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic glitch = 1'b0;
  logic [1:0] mode = 2'd0;
  logic dut_out;
  logic drv_in1, drv_in2, drv_in3, busy, done, pass;
  logic [7:0] captured, unstable;

  logic start_b = 1'b0;
  logic dut_out_b;
  logic drv_in1_b, drv_in2_b, drv_in3_b, busy_b, done_b, pass_b;
  logic [7:0] captured_b, unstable_b;

  logic [7:0] tt = 8'h76;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // mode 0: 0x76 cell (optionally glitched), mode 1: stuck at 0
  assign dut_out = (mode == 2'd1) ? 1'b0 : (tt[3'd7 - {drv_in1, drv_in2, drv_in3}] ^ glitch);
  assign dut_out_b = ~drv_in3_b;

  truth_table_sweeper dut (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out),
    .drv_in1(drv_in1), .drv_in2(drv_in2), .drv_in3(drv_in3),
    .busy(busy), .done(done), .captured(captured), .unstable(unstable), .pass(pass)
  );

  truth_table_sweeper #(.TRUTH(8'h76), .SETTLE_CYCLES(1), .STABLE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_out(dut_out_b),
    .drv_in1(drv_in1_b), .drv_in2(drv_in2_b), .drv_in3(drv_in3_b),
    .busy(busy_b), .done(done_b), .captured(captured_b), .unstable(unstable_b), .pass(pass_b)
  );

  task automatic issue_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || {drv_in1, drv_in2, drv_in3} !== 3'b000) begin
      n_fail++;
      $display("FAIL start_accept: busy=%b drv=%b, want busy=1 drv=000", busy, {drv_in1, drv_in2, drv_in3});
    end
  endtask

  // Runs 48 edges past E0 checking vector timing and busy/done, then checks results.
  task automatic run_sweep(input string name, input logic [7:0] exp_cap, input logic [7:0] exp_unst,
                           input logic exp_pass);
    int bad_vec = 0;
    int bad_busy = 0;
    for (int j = 1; j <= 48; j++) begin
      @(posedge clk);
      #1;
      if (j < 48) begin
        if ({drv_in1, drv_in2, drv_in3} !== 3'(j / 6)) bad_vec++;
        if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
      end
    end
    n_checks++;
    if (bad_vec != 0) begin
      n_fail++;
      $display("FAIL %s_vectors: %0d cycles with wrong vector, want 0", name, bad_vec);
    end
    n_checks++;
    if (bad_busy != 0) begin
      n_fail++;
      $display("FAIL %s_busy: %0d cycles with bad busy/done, want 0", name, bad_busy);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || {drv_in1, drv_in2, drv_in3} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s_end: done=%b busy=%b drv=%b, want 1 0 000", name, done, busy,
               {drv_in1, drv_in2, drv_in3});
    end
    n_checks++;
    if (captured !== exp_cap || unstable !== exp_unst || pass !== exp_pass) begin
      n_fail++;
      $display("FAIL %s_result: captured=%h unstable=%b pass=%b, want %h %b %b", name, captured,
               unstable, pass, exp_cap, exp_unst, exp_pass);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || captured !== exp_cap || pass !== exp_pass) begin
      n_fail++;
      $display("FAIL %s_hold: done=%b captured=%h pass=%b, want 0 %h %b", name, done, captured, pass,
               exp_cap, exp_pass);
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({drv_in1, drv_in2, drv_in3, busy, done, pass} !== 6'b0 || captured !== 8'h00 || unstable !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: drv=%b busy=%b done=%b captured=%h unstable=%h pass=%b, want all 0",
               {drv_in1, drv_in2, drv_in3}, busy, done, captured, unstable, pass);
    end
    n_checks++;
    if ({busy_b, done_b, pass_b} !== 3'b0 || captured_b !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state_b: busy=%b done=%b pass=%b captured=%h, want 0", busy_b, done_b, pass_b, captured_b);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_good_cell();
    mode = 2'd0;
    issue_start();
    run_sweep("good", 8'h76, 8'h00, 1'b1);
  endtask

  task automatic test_stuck_zero();
    mode = 2'd1;
    issue_start();
    run_sweep("stuck0", 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_unstable();
    mode = 2'd0;
    issue_start();
    // vector 5 samples at E0+35 (reference) and E0+36 (compare)
    for (int j = 1; j <= 35; j++) begin
      @(posedge clk);
      #1;
    end
    glitch = 1'b1;
    @(posedge clk);
    #1;
    glitch = 1'b0;
    for (int j = 37; j <= 48; j++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (done !== 1'b1 || captured !== 8'h76 || unstable !== 8'b0000_0100 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL unstable_result: done=%b captured=%h unstable=%b pass=%b, want 1 76 00000100 0",
               done, captured, unstable, pass);
    end
  endtask

  task automatic test_back_to_back();
    int early_done = 0;
    mode = 2'd0;
    issue_start();
    for (int j = 1; j <= 47; j++) begin
      if (j == 10) start = 1'b1;
      if (j == 11) start = 1'b0;
      if (j == 47) start = 1'b1;
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b1) early_done++;
    end
    n_checks++;
    if (early_done != 0) begin
      n_fail++;
      $display("FAIL b2b_ignored: %0d cycles with done or !busy before E0+48, want 0", early_done);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || captured !== 8'h76 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done48: done=%b busy=%b captured=%h pass=%b, want 1 0 76 1", done, busy, captured, pass);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || captured !== 8'h00 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_restart49: done=%b busy=%b captured=%h pass=%b, want 0 1 00 0", done, busy, captured, pass);
    end
  endtask

  task automatic test_abort_reset();
    int seen_done = 0;
    mode = 2'd0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue_start();
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if ({drv_in1, drv_in2, drv_in3} !== 3'b011) begin
      n_fail++;
      $display("FAIL abort_pre: drv=%b, want 011", {drv_in1, drv_in2, drv_in3});
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || {drv_in1, drv_in2, drv_in3} !== 3'b000 || captured !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_async: busy=%b drv=%b captured=%h, want 0 000 00", busy,
               {drv_in1, drv_in2, drv_in3}, captured);
    end
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 30; j++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
    end
    n_checks++;
    if (seen_done != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: %0d cycles with done/busy after abort, want 0", seen_done);
    end
    issue_start();
    run_sweep("after_abort", 8'h76, 8'h00, 1'b1);
  endtask

  task automatic test_short_params();
    int early = 0;
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    for (int j = 1; j <= 15; j++) begin
      @(posedge clk);
      #1;
      if (done_b !== 1'b0 || busy_b !== 1'b1 || {drv_in1_b, drv_in2_b, drv_in3_b} !== 3'(j / 2)) early++;
    end
    n_checks++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL short_timing: %0d bad cycles before E0+16, want 0", early);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done_b !== 1'b1 || busy_b !== 1'b0 || captured_b !== 8'hAA || unstable_b !== 8'h00 || pass_b !== 1'b0) begin
      n_fail++;
      $display("FAIL short_result: done=%b busy=%b captured=%h unstable=%h pass=%b, want 1 0 aa 00 0",
               done_b, busy_b, captured_b, unstable_b, pass_b);
    end
  endtask

  initial begin
    test_reset();
    test_good_cell();
    test_stuck_zero();
    test_unstable();
    test_back_to_back();
    test_abort_reset();
    test_short_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
